// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop sync, debounce FSM, press/release/long pulses per channel.
// Define BTN_REPEAT_EN to add auto-repeat pulses after a long press.
module btn_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    typedef enum logic [1:0] {
        RELEASED,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } state_e;

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_err
        $error("btn_conditioner: cycle parameters must be >= 1");
    end

    logic [NUM_BTN-1:0] sync1_q, sync2_q;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        state_e        state_q, state_d;
        logic [DW-1:0] db_q, db_d;
        logic [HW-1:0] hold_q, hold_d;
        logic          fired_q, fired_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;
        logic          s;

        assign s = sync2_q[g];

        always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
                state_q <= RELEASED;
                db_q    <= '0;
                hold_q  <= '0;
                fired_q <= 1'b0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                db_q    <= db_d;
                hold_q  <= hold_d;
                fired_q <= fired_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
            end
        end

        always_comb begin
            state_d = state_q;
            db_d    = db_q;
            unique case (state_q)
                RELEASED: begin
                    if (s) begin
                        state_d = DB_PRESS;
                        db_d    = '0;
                    end
                end
                DB_PRESS: begin
                    if (!s)                 state_d = RELEASED;
                    else if (db_q == DB_LAST) state_d = PRESSED;
                    else                    db_d = db_q + 1'b1;
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = DB_RELEASE;
                        db_d    = '0;
                    end
                end
                DB_RELEASE: begin
                    if (s)                  state_d = PRESSED;
                    else if (db_q == DB_LAST) state_d = RELEASED;
                    else                    db_d = db_q + 1'b1;
                end
                default: state_d = RELEASED;
            endcase
        end

        // Hold time only advances while settled in PRESSED; DB_RELEASE freezes it.
        always_comb begin
            press_d = (state_q == DB_PRESS) && (state_d == PRESSED);
            rel_d   = (state_q == DB_RELEASE) && (state_d == RELEASED);
            level_d = (state_d == PRESSED) || (state_d == DB_RELEASE);
            hold_d  = hold_q;
            fired_d = fired_q;
            long_d  = 1'b0;
            if (press_d) begin
                hold_d = '0;
            end else if (state_q == PRESSED) begin
                if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST && !fired_q) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end
            end
            if (rel_d) fired_d = 1'b0;
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = rel_q;
        assign btn_long[g]    = long_q;

`ifdef BTN_REPEAT_EN
        localparam int RW = $clog2(REPEAT_CYCLES + 1);
        localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

        logic [RW-1:0] rep_q, rep_d;
        logic          repeat_q, repeat_d;

        always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
                rep_q    <= '0;
                repeat_q <= 1'b0;
            end else begin
                rep_q    <= rep_d;
                repeat_q <= repeat_d;
            end
        end

        always_comb begin
            rep_d    = rep_q;
            repeat_d = 1'b0;
            if (state_q == RELEASED) begin
                rep_d = '0;
            end else if (state_q == PRESSED && fired_q) begin
                if (rep_q == REP_LAST) begin
                    rep_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
        end

        assign btn_repeat[g] = repeat_q;
`else
        assign btn_repeat[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: run-length reference model feeds a queue,
// a negedge monitor pops and compares every cycle.
module tb_btn_conditioner;

    localparam int NB = 2;
    localparam int DB = 4;
    localparam int LG = 20;
    localparam int RP = 8;
`ifdef BTN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] lvl_o, prs_o, rel_o, lng_o, rep_o;

    btn_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .REPEAT_CYCLES  (RP)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (lvl_o),
        .btn_press  (prs_o),
        .btn_release(rel_o),
        .btn_long   (lng_o),
        .btn_repeat (rep_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic [NB-1:0] lng;
        logic [NB-1:0] rep;
    } obs_t;

    obs_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    // Reference: a level change is accepted once the synced input has
    // disagreed with the level for DB+1 consecutive samples.
    int h1[NB], h2[NB], lvl[NB], run[NB], hold[NB], fired[NB], rcnt[NB];
    int m_s;
    bit m_pp, m_fp;
    obs_t m_e;

    always @(posedge clk) begin
        m_e = '0;
        for (int c = 0; c < NB; c++) begin
            if (!rst_n) begin
                h1[c] = 0; h2[c] = 0; lvl[c] = 0; run[c] = 0;
                hold[c] = 0; fired[c] = 0; rcnt[c] = 0;
            end else begin
                m_s   = h2[c];
                h2[c] = h1[c];
                h1[c] = int'(btn_raw[c]);
                m_pp  = (lvl[c] == 1) && (run[c] == 0);
                m_fp  = (fired[c] != 0);
                if (m_pp) begin
                    if (hold[c] < LG) hold[c]++;
                    if (hold[c] == LG && !m_fp) begin
                        m_e.lng[c] = 1'b1;
                        fired[c] = 1;
                    end
                    if (REP_EN && m_fp) begin
                        rcnt[c]++;
                        if (rcnt[c] == RP) begin
                            m_e.rep[c] = 1'b1;
                            rcnt[c] = 0;
                        end
                    end
                end
                run[c] = (m_s != lvl[c]) ? run[c] + 1 : 0;
                if (run[c] == DB + 1) begin
                    run[c] = 0;
                    lvl[c] = 1 - lvl[c];
                    if (lvl[c] == 1) begin
                        m_e.prs[c] = 1'b1;
                        hold[c] = 0;
                    end else begin
                        m_e.rel[c] = 1'b1;
                        fired[c] = 0;
                        rcnt[c] = 0;
                    end
                end
            end
            m_e.lvl[c] = (lvl[c] != 0);
        end
        sb_q.push_back(m_e);
        mon_en = 1'b1;
    end

    obs_t mon_a, mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_a = {lvl_o, prs_o, rel_o, lng_o, rep_o};
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty t=%0t got %b required an entry", $time, mon_a);
            end else begin
                mon_e = sb_q.pop_front();
                if (!rst_n) mon_e = '0;
                if (mon_a !== mon_e) begin
                    miscompares++;
                    $display("FAIL cycle_outputs t=%0t got lvl=%b prs=%b rel=%b lng=%b rep=%b required lvl=%b prs=%b rel=%b lng=%b rep=%b",
                             $time, mon_a.lvl, mon_a.prs, mon_a.rel, mon_a.lng, mon_a.rep,
                             mon_e.lvl, mon_e.prs, mon_e.rel, mon_e.lng, mon_e.rep);
                end
            end
        end
    end

    task automatic drive(input logic [NB-1:0] r, input int n);
        repeat (n) begin
            btn_raw = r;
            @(negedge clk);
        end
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({lvl_o, prs_o, rel_o, lng_o, rep_o} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_%s got %b required 0", tag,
                     {lvl_o, prs_o, rel_o, lng_o, rep_o});
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    logic [NB-1:0] rr;

    initial begin
        rst_n   = 1'b0;
        btn_raw = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        drive(2'b00, 3);
        // clean press
        drive(2'b01, 12);
        drive(2'b00, 10);
        // glitch
        drive(2'b01, 3);
        drive(2'b00, 8);
        // bounce
        repeat (3) begin
            drive(2'b01, 2);
            drive(2'b00, 2);
        end
        drive(2'b01, 10);
        drive(2'b00, 10);
        // long hold
        drive(2'b01, 50);
        drive(2'b00, 10);
        // reset mid-debounce, raw held through reset
        drive(2'b01, 3);
        async_reset("debounce");
        drive(2'b01, 15);
        drive(2'b00, 10);
        // reset while level is high
        drive(2'b01, 12);
        async_reset("pressed");
        drive(2'b00, 10);
        // simultaneous channels
        drive(2'b11, 10);
        drive(2'b01, 10);
        drive(2'b00, 10);
        // random segments
        repeat (60) begin
            rr = NB'($urandom_range(0, 3));
            drive(rr, $urandom_range(1, 32));
            if ($urandom_range(0, 19) == 0) async_reset("random");
        end
        drive(2'b00, 12);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
